// File: rtl/excess3_pkg.sv
// Shared constants and FSM encoding for the Excess-3 decode path.
package excess3_pkg;

  localparam logic [3:0] E3_OFFSET   = 4'd3;
  localparam logic [3:0] E3_MIN      = 4'd3;
  localparam logic [3:0] E3_MAX      = 4'd12;
  localparam logic [3:0] BCD_ILLEGAL = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/excess3_digit_decode.sv
// Combinational Excess-3 to BCD digit decoder; illegal codes map to 4'hF.
module excess3_digit_decode
  import excess3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       illegal
);

  assign illegal = (code < E3_MIN) || (code > E3_MAX);
  assign bcd     = illegal ? BCD_ILLEGAL : (code - E3_OFFSET);

endmodule

// File: rtl/excess3_to_bcd_packer.sv
// Packs a serial Excess-3 digit stream (MSD first) into DIGITS-wide BCD words.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   COLLECT | accepting digits, shifting decoded nibbles into out_word
//   HOLD    | word complete, out_valid high until downstream takes it
module excess3_to_bcd_packer
  import excess3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [3:0]                         in_digit,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [4*DIGITS-1:0]                out_word,
  output logic                               out_err,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [((DIGITS == 8) ? 4 : 3)-1:0] digit_count
);

  localparam int CW = (DIGITS == 8) ? 4 : 3;
  localparam int WW = 4 * DIGITS;

  state_t          state;
  state_t          state_nx;
  logic [WW-1:0]   word_nx;
  logic            err_nx;
  logic [CW-1:0]   count_nx;
  logic [3:0]      bcd;
  logic            illegal;

  excess3_digit_decode u_decode (
    .code    (in_digit),
    .bcd     (bcd),
    .illegal (illegal)
  );

  assign in_ready  = (state == COLLECT) && !flush;
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      out_word    <= '0;
      out_err     <= 1'b0;
      digit_count <= '0;
    end else begin
      state       <= state_nx;
      out_word    <= word_nx;
      out_err     <= err_nx;
      digit_count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    word_nx  = out_word;
    err_nx   = out_err;
    count_nx = digit_count;
    case (state)
      COLLECT: begin
        if (flush) begin
          word_nx  = '0;
          err_nx   = 1'b0;
          count_nx = '0;
        end else if (in_valid) begin
          word_nx      = out_word << 4;
          word_nx[3:0] = bcd;
          err_nx       = out_err | illegal;
          if (digit_count == CW'(DIGITS - 1)) begin
            count_nx = '0;
            state_nx = HOLD;
          end else begin
            count_nx = digit_count + CW'(1);
          end
        end
      end
      HOLD: begin
        // flush is deliberately ignored here so a finished word is never lost
        if (out_ready) begin
          state_nx = COLLECT;
          word_nx  = '0;
          err_nx   = 1'b0;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_excess3_to_bcd_packer.sv
// Bench for excess3_to_bcd_packer: directed scenarios plus randomized traffic vs a queue model.
module tb_excess3_to_bcd_packer;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [3:0]    in_digit = 4'h0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4*D-1:0] out_word;
  logic          out_err;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    digit_count;

  logic [3:0]    dec_code = 4'h0;
  logic [3:0]    dec_bcd;
  logic          dec_illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit         m_hold = 1'b0;
  logic [3:0] m_q[$];

  always #5 clk = ~clk;

  excess3_to_bcd_packer #(.DIGITS(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_digit    (in_digit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_word    (out_word),
    .out_err     (out_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .digit_count (digit_count)
  );

  excess3_digit_decode dec (
    .code    (dec_code),
    .bcd     (dec_bcd),
    .illegal (dec_illegal)
  );

  function automatic bit code_bad(input logic [3:0] c);
    return (c < 3) || (c > 12);
  endfunction

  function automatic logic [3:0] code_nib(input logic [3:0] c);
    int v;
    v = c;
    if (code_bad(c)) return 4'hF;
    return 4'(v - 3);
  endfunction

  function automatic logic [4*D-1:0] exp_word();
    longint w;
    w = 0;
    foreach (m_q[i]) w = w * 16 + code_nib(m_q[i]);
    return (4*D)'(w);
  endfunction

  function automatic bit exp_err();
    bit e;
    e = 1'b0;
    foreach (m_q[i]) e |= code_bad(m_q[i]);
    return e;
  endfunction

  // Model of one clock edge: m_q keeps the collected digits until the word is handed off.
  task automatic model_edge(input bit v, input logic [3:0] d, input bit f, input bit r);
    if (m_hold) begin
      if (r) begin
        m_hold = 1'b0;
        m_q.delete();
      end
    end else if (f) begin
      m_q.delete();
    end else if (v) begin
      m_q.push_back(d);
      if (m_q.size() == D) m_hold = 1'b1;
    end
  endtask

  task automatic step(input bit v, input logic [3:0] d, input bit f, input bit r);
    @(negedge clk);
    in_valid = v;
    in_digit = d;
    flush    = f;
    out_ready = r;
    @(posedge clk);
    model_edge(v, d, f, r);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_word !== 16'h0) $display("FAIL reset_word: got %h want 0000", out_word); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b0) $display("FAIL reset_err: got %b want 0", out_err); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", digit_count); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_word();
    step(1, 4'h4, 0, 1);
    total_cnt++; if (digit_count !== 3'd1) $display("FAIL basic_count1: got %0d want 1", digit_count); else pass_cnt++;
    step(1, 4'h8, 0, 1);
    step(1, 4'hC, 0, 1);
    step(1, 4'h3, 0, 1);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_word !== 16'h1590) $display("FAIL basic_word: got %h want 1590", out_word); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b0) $display("FAIL basic_err: got %b want 0", out_err); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_ready_hold: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL basic_count_wrap: got %0d want 0", digit_count); else pass_cnt++;
    step(0, 4'h0, 0, 1);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_word !== 16'h0) $display("FAIL basic_word_clear: got %h want 0000", out_word); else pass_cnt++;
  endtask

  task automatic test_illegal();
    step(1, 4'h5, 0, 1);
    step(1, 4'h2, 0, 1);
    step(1, 4'h7, 0, 1);
    step(1, 4'hD, 0, 1);
    total_cnt++; if (out_word !== 16'h2F4F) $display("FAIL illegal_word: got %h want 2f4f", out_word); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b1) $display("FAIL illegal_err: got %b want 1", out_err); else pass_cnt++;
    step(0, 4'h0, 0, 1);
    total_cnt++; if (out_err !== 1'b0) $display("FAIL illegal_err_clear: got %b want 0", out_err); else pass_cnt++;
    repeat (4) step(1, 4'h3, 0, 1);
    total_cnt++; if (out_word !== 16'h0000) $display("FAIL zeros_word: got %h want 0000", out_word); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b0) $display("FAIL zeros_err: got %b want 0", out_err); else pass_cnt++;
    step(0, 4'h0, 0, 1);
  endtask

  task automatic test_backpressure();
    repeat (4) step(1, 4'hC, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 4'h4, (i == 2), 0);
      total_cnt++; if (out_word !== 16'h9999) $display("FAIL bp_word[%0d]: got %h want 9999", i, out_word); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else pass_cnt++;
    end
    step(0, 4'h0, 0, 1);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_release: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_flush();
    step(1, 4'h7, 0, 1);
    step(1, 4'h9, 0, 1);
    total_cnt++; if (digit_count !== 3'd2) $display("FAIL flush_pre_count: got %0d want 2", digit_count); else pass_cnt++;
    step(1, 4'hA, 1, 1);
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL flush_count: got %0d want 0", digit_count); else pass_cnt++;
    total_cnt++; if (out_word !== 16'h0) $display("FAIL flush_word: got %h want 0000", out_word); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", in_ready); else pass_cnt++;
    step(1, 4'h4, 0, 1);
    step(1, 4'h5, 0, 1);
    step(1, 4'h6, 0, 1);
    step(1, 4'h7, 0, 1);
    total_cnt++; if (out_word !== 16'h1234) $display("FAIL flush_next_word: got %h want 1234", out_word); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL flush_next_valid: got %b want 1", out_valid); else pass_cnt++;
    step(0, 4'h0, 0, 1);
  endtask

  task automatic test_async_reset();
    step(1, 4'h4, 0, 1);
    step(1, 4'h5, 0, 1);
    step(1, 4'h6, 0, 1);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    m_hold = 1'b0;
    m_q.delete();
    #1;
    total_cnt++; if (out_word !== 16'h0) $display("FAIL arst_word: got %h want 0000", out_word); else pass_cnt++;
    total_cnt++; if (digit_count !== 3'd0) $display("FAIL arst_count: got %0d want 0", digit_count); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", out_valid); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1, 4'h3, 0, 1);
    total_cnt++; if (out_word !== 16'h0000) $display("FAIL arst_next_word: got %h want 0000", out_word); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b0) $display("FAIL arst_next_err: got %b want 0", out_err); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL arst_next_valid: got %b want 1", out_valid); else pass_cnt++;
    step(0, 4'h0, 0, 1);
  endtask

  task automatic test_decode_exhaustive();
    for (int c = 0; c < 16; c++) begin
      logic [3:0] want_bcd;
      bit want_bad;
      dec_code = 4'(c);
      want_bad = (c < 3) || (c > 12);
      want_bcd = want_bad ? 4'hF : 4'(c - 3);
      #1;
      total_cnt++; if (dec_bcd !== want_bcd) $display("FAIL dec_bcd[%0d]: got %h want %h", c, dec_bcd, want_bcd); else pass_cnt++;
      total_cnt++; if (dec_illegal !== want_bad) $display("FAIL dec_illegal[%0d]: got %b want %b", c, dec_illegal, want_bad); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    bit v, f, r;
    logic [3:0] d;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 4'($urandom_range(0, 15));
      f = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      in_valid = v;
      in_digit = d;
      flush = f;
      out_ready = r;
      #1;
      total_cnt++; if (in_ready !== (!m_hold && !f)) $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, (!m_hold && !f)); else pass_cnt++;
      total_cnt++; if (out_valid !== m_hold) $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_hold); else pass_cnt++;
      total_cnt++; if (digit_count !== (m_hold ? 3'd0 : 3'(m_q.size()))) $display("FAIL rnd_count[%0d]: got %0d want %0d", i, digit_count, m_hold ? 0 : m_q.size()); else pass_cnt++;
      total_cnt++; if (out_word !== exp_word()) $display("FAIL rnd_word[%0d]: got %h want %h", i, out_word, exp_word()); else pass_cnt++;
      total_cnt++; if (out_err !== exp_err()) $display("FAIL rnd_err[%0d]: got %b want %b", i, out_err, exp_err()); else pass_cnt++;
      @(posedge clk);
      model_edge(v, d, f, r);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_decode_exhaustive();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/excess3_to_bcd_packer.md
Name: excess3_to_bcd_packer

Overview:
Receives a serial stream of Excess-3 coded decimal digits, most significant digit first, over a valid/ready handshake. Each digit is converted back to BCD by subtracting 3. DIGITS converted digits are packed into one BCD word, which is presented on a valid/ready output handshake. This is the decode-side counterpart of the team's BCD-to-Excess-3 converters. It sits between a digit-serial link receiver and the BCD display/arithmetic path.

Parameters:
DIGITS, 4, number of decimal digits packed per output word (legal range 1..8).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous discard of any partially collected word.
in_digit  input  4  Excess-3 code of one digit.
in_valid  input  1  in_digit is valid.
in_ready  output  1  packer accepts a digit this cycle.
out_word  output  4*DIGITS  packed BCD word; the first-received digit is in the most significant nibble.
out_err  output  1  one or more digits in out_word had an illegal Excess-3 code.
out_valid  output  1  out_word and out_err are valid.
out_ready  input  1  downstream accepts the word.
digit_count  output  3 (4 if DIGITS=8)  number of digits collected in the current word.

Behaviour:
- Reset value of every register is 0: out_word=0, out_err=0, out_valid=0, digit_count=0, state=COLLECT. Reset takes effect immediately on rst_n low, including mid-word or mid-hold; the partial word is lost.
- State COLLECT:
  - in_ready = !flush (combinational). out_valid=0.
  - Digit accept: in_valid & in_ready. On accept, out_word shifts left 4 bits and the decoded nibble enters the LSBs. digit_count increments. out_err is ORed with the invalid flag of the digit.
  - When the accept brings digit_count to DIGITS: digit_count returns to 0, state moves to HOLD, and out_valid=1 from the next cycle. Latency from the last accepted digit to out_valid is 1 cycle.
- State HOLD:
  - out_valid=1 and in_ready=0. out_word and out_err are held stable until handshake.
  - When out_valid & out_ready: state returns to COLLECT, out_err clears, and out_word clears to 0. The next digit may be accepted on the cycle after the handshake. Throughput is therefore at most DIGITS digits per DIGITS+1 cycles.
- Decode rule: legal codes are 3..12, giving BCD = code-3 in 4-bit arithmetic. Codes 0,1,2 and 13,14,15 are illegal: the stored nibble is 4'hF and the digit's invalid flag is set. An illegal digit is still accepted and still counted.
- flush:
  - In COLLECT: digit_count, out_word and out_err clear to 0 at the next edge. A digit presented on the same cycle is not accepted (in_ready=0).
  - In HOLD: flush is ignored and the completed word is still delivered.
- out_ready while in COLLECT is ignored.
- DIGITS=1: every accepted digit moves the block to HOLD.

Decomposition:
- Package excess3_pkg:
  - constants E3_OFFSET=4'd3, E3_MIN=4'd3, E3_MAX=4'd12, BCD_ILLEGAL=4'hF.
  - state encoding COLLECT=1'b0, HOLD=1'b1.
- Sub-module excess3_digit_decode (combinational): in code[3:0]; out bcd[3:0] and illegal. It is instantiated once in the packer and is reusable elsewhere.

Test Plan:
1. DIGITS=4, out_ready=1. Send digits 0x4,0x8,0xC,0x3 on consecutive cycles -> one cycle after the fourth accept: out_valid=1, out_word=16'h1590, out_err=0. in_ready=0 for that one cycle.
2. Send 0x5,0x2,0x7,0xD -> out_word=16'h2F4F, out_err=1. The next word 0x3,0x3,0x3,0x3 -> out_word=16'h0000, out_err=0 (error does not persist).
3. Backpressure: complete word 0xC,0xC,0xC,0xC with out_ready=0 for 5 cycles -> out_word=16'h9999 stable and in_ready=0 throughout. Raise out_ready -> out_valid drops on the next cycle.
4. Flush: accept 0x7,0x9, then assert flush with in_valid=1 and in_digit=0xA -> digit_count=0 next cycle and 0xA is not accepted. Then send 0x4,0x5,0x6,0x7 -> out_word=16'h1234.
5. Reset: accept 0x4,0x5,0x6, drop rst_n asynchronously mid-cycle -> all outputs 0 immediately. After release, send four 0x3 digits -> out_word=16'h0000, out_err=0.
6. Exhaustive decode: drive codes 0x0..0xF through excess3_digit_decode -> bcd = code-3 for codes 3..12; bcd=0xF and illegal=1 for codes 0-2 and 13-15.
